// File: rtl/commit_serializer.sv
// Serialises up to NRET commit slots per cycle into one trace uop per cycle,
// in program order. Commit cannot stall, so excess slots are dropped and counted.
module commit_serializer #(
    parameter int NRET         = 2,
    parameter int DEPTH        = 8,
    parameter int DROP_CNT_LEN = 16,
    parameter int XLEN         = 32,
    parameter int ITYPE_LEN    = 3,
    parameter int PRIV_LEN     = 2,
    parameter int CAUSE_LEN    = 5,
    // uop_entry_o packing, MSB first: {valid, pc, itype, compressed, priv}
    localparam int UOP_LEN     = 1 + XLEN + ITYPE_LEN + 1 + PRIV_LEN,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NRET-1:0]           valid_i,
    input  logic [NRET*XLEN-1:0]      pc_i,
    input  logic [NRET-1:0]           compressed_i,
    input  logic [NRET*ITYPE_LEN-1:0] itype_i,
    input  logic [PRIV_LEN-1:0]       priv_i,
    input  logic [CAUSE_LEN-1:0]      cause_i,
    input  logic [XLEN-1:0]           tval_i,
    output logic [UOP_LEN-1:0]        uop_entry_o,
    output logic [CAUSE_LEN-1:0]      cause_o,
    output logic [XLEN-1:0]           tval_o,
    output logic [CNT_W-1:0]          occupancy_o,
    output logic                      overflow_o,
    output logic [DROP_CNT_LEN-1:0]   drop_cnt_o
);

    localparam int DSUM_W = DROP_CNT_LEN + 1;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [ITYPE_LEN-1:0] itype;
        logic                 compressed;
        logic [PRIV_LEN-1:0]  priv;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } slot_t;

    slot_t             mem [DEPTH];
    slot_t             in_slot [NRET];
    slot_t             head;
    logic [NRET-1:0]   trap;
    logic [NRET-1:0]   live;
    logic [NRET-1:0]   accept;
    logic [PTR_W-1:0]  wr_addr [NRET];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free_slots;
    logic [CNT_W-1:0]  n_accept;
    logic [CNT_W-1:0]  n_drop;
    logic              pop;
    logic [DSUM_W-1:0] drop_sum;

    // Trap slots carry cause/tval even without a retired instruction.
    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            trap[k] = (itype_i[k*ITYPE_LEN +: ITYPE_LEN] == ITYPE_LEN'(1))
                   || (itype_i[k*ITYPE_LEN +: ITYPE_LEN] == ITYPE_LEN'(2));
            live[k] = valid_i[k] | trap[k];
            in_slot[k].valid      = valid_i[k];
            in_slot[k].pc         = pc_i[k*XLEN +: XLEN];
            in_slot[k].itype      = itype_i[k*ITYPE_LEN +: ITYPE_LEN];
            in_slot[k].compressed = compressed_i[k];
            in_slot[k].priv       = priv_i;
            in_slot[k].cause      = trap[k] ? cause_i : '0;
            in_slot[k].tval       = trap[k] ? tval_i : '0;
        end
    end

    // The head leaves this cycle, so its slot counts as free for the pushes.
    always_comb begin
        pop        = (count != '0);
        free_slots = CNT_W'(DEPTH) - count + CNT_W'(pop);
        n_accept   = '0;
        n_drop     = '0;
        accept     = '0;
        for (int k = 0; k < NRET; k++) begin
            wr_addr[k] = wr_ptr + n_accept[PTR_W-1:0];
            if (live[k]) begin
                if (n_accept < free_slots) begin
                    accept[k] = 1'b1;
                    n_accept  = n_accept + CNT_W'(1);
                end else begin
                    n_drop = n_drop + CNT_W'(1);
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt_o} + DSUM_W'(n_drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            wr_ptr <= wr_ptr + n_accept[PTR_W-1:0];
            count  <= count - CNT_W'(pop) + n_accept;
            if (n_drop != '0) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum[DROP_CNT_LEN] ? '1 : drop_sum[DROP_CNT_LEN-1:0];
            end
        end
    end

    // Storage needs no reset: the output is masked whenever count is zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NRET; k++) begin
                if (accept[k]) begin
                    mem[wr_addr[k]] <= in_slot[k];
                end
            end
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        uop_entry_o = '0;
        cause_o     = '0;
        tval_o      = '0;
        if (count != '0) begin
            uop_entry_o = {head.valid, head.pc, head.itype, head.compressed, head.priv};
            cause_o     = head.cause;
            tval_o      = head.tval;
        end
    end

    assign occupancy_o = count;

endmodule

// File: tb/tb_commit_serializer.sv
// Bench for commit_serializer: a table of dual-commit/trap vectors, hand-written
// stream/overflow/wrap/reset sequences, and random traffic against a queue model.
module tb_commit_serializer;

    localparam int NRET = 2, DEPTH = 8, DROP_CNT_LEN = 16;
    localparam int XLEN = 32, ITYPE_LEN = 3, PRIV_LEN = 2, CAUSE_LEN = 5;
    localparam int UOP_LEN = 1 + XLEN + ITYPE_LEN + 1 + PRIV_LEN;
    localparam int DROP_MAX = (1 << DROP_CNT_LEN) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NRET-1:0]           valid;
    logic [NRET*XLEN-1:0]      pc;
    logic [NRET-1:0]           compressed;
    logic [NRET*ITYPE_LEN-1:0] itype;
    logic [PRIV_LEN-1:0]       priv;
    logic [CAUSE_LEN-1:0]      cause;
    logic [XLEN-1:0]           tval;
    logic [UOP_LEN-1:0]        uop_entry;
    logic [CAUSE_LEN-1:0]      cause_out;
    logic [XLEN-1:0]           tval_out;
    logic [$clog2(DEPTH):0]    occupancy;
    logic                      overflow;
    logic [DROP_CNT_LEN-1:0]   drop_cnt;

    commit_serializer #(
        .NRET(NRET), .DEPTH(DEPTH), .DROP_CNT_LEN(DROP_CNT_LEN), .XLEN(XLEN),
        .ITYPE_LEN(ITYPE_LEN), .PRIV_LEN(PRIV_LEN), .CAUSE_LEN(CAUSE_LEN)
    ) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc),
        .compressed_i(compressed), .itype_i(itype), .priv_i(priv),
        .cause_i(cause), .tval_i(tval), .uop_entry_o(uop_entry),
        .cause_o(cause_out), .tval_o(tval_out), .occupancy_o(occupancy),
        .overflow_o(overflow), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [ITYPE_LEN-1:0] itype;
        logic                 comp;
        logic [PRIV_LEN-1:0]  priv;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } ent_t;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] pc0, pc1;
        logic [2:0]  it0, it1;
        logic [4:0]  ca;
        logic [31:0] tv;
        logic        e_any, e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_it;
        logic [4:0]  e_ca;
        logic [31:0] e_tv;
        logic [3:0]  e_occ;
    } vec_t;

    ent_t        model_q[$];
    logic        model_ovf;
    int unsigned model_drops;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vecs[13];
    logic [31:0] emitted[$];

    // Program-order queue: pop the head, then admit live slots while room remains.
    function automatic void model_edge();
        int n, room;
        logic [ITYPE_LEN-1:0] it;
        bit is_trap;
        ent_t e;
        if (rst) begin
            model_q.delete();
            model_ovf   = 1'b0;
            model_drops = 0;
            return;
        end
        n    = model_q.size();
        room = DEPTH - n + ((n > 0) ? 1 : 0);
        if (n > 0) void'(model_q.pop_front());
        for (int k = 0; k < NRET; k++) begin
            it      = itype[k*ITYPE_LEN +: ITYPE_LEN];
            is_trap = (it == 1) || (it == 2);
            if (valid[k] || is_trap) begin
                if (room > 0) begin
                    e.valid = valid[k];
                    e.pc    = pc[k*XLEN +: XLEN];
                    e.itype = it;
                    e.comp  = compressed[k];
                    e.priv  = priv;
                    e.cause = is_trap ? cause : '0;
                    e.tval  = is_trap ? tval : '0;
                    model_q.push_back(e);
                    room--;
                end else begin
                    model_ovf = 1'b1;
                    if (model_drops < DROP_MAX) model_drops++;
                end
            end
        end
    endfunction

    function automatic vec_t mk(input logic [1:0] v, input logic [31:0] pc0, pc1,
                                input logic [2:0] it0, it1, input logic [4:0] ca,
                                input logic [31:0] tv, input logic e_any, e_valid,
                                input logic [31:0] e_pc, input logic [2:0] e_it,
                                input logic [4:0] e_ca, input logic [31:0] e_tv,
                                input logic [3:0] e_occ);
        return '{v, pc0, pc1, it0, it1, ca, tv, e_any, e_valid, e_pc, e_it, e_ca, e_tv, e_occ};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] v, input logic [31:0] p0, p1,
                                  input logic [1:0] c, input logic [2:0] i0, i1,
                                  input logic [1:0] pr, input logic [4:0] ca,
                                  input logic [31:0] tv);
        valid      = v;
        pc         = {p1, p0};
        compressed = c;
        itype      = {i1, i0};
        priv       = pr;
        cause      = ca;
        tval       = tv;
    endtask

    task automatic idle();
        apply_stimulus(2'b00, 32'h0, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 5'd0, 32'h0);
    endtask

    task automatic check_output(input string tag);
        ent_t e;
        logic [UOP_LEN-1:0] u;
        e = '0;
        if (model_q.size() > 0) e = model_q[0];
        u = {e.valid, e.pc, e.itype, e.comp, e.priv};
        cmp($sformatf("%s.uop", tag), 64'(uop_entry), 64'(u));
        cmp($sformatf("%s.cause", tag), 64'(cause_out), 64'(e.cause));
        cmp($sformatf("%s.tval", tag), 64'(tval_out), 64'(e.tval));
        cmp($sformatf("%s.occ", tag), 64'(occupancy), 64'(model_q.size()));
        cmp($sformatf("%s.ovf", tag), 64'(overflow), 64'(model_ovf));
        cmp($sformatf("%s.drops", tag), 64'(drop_cnt), 64'(model_drops));
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] out_pc();
        return uop_entry[UOP_LEN-2 -: XLEN];
    endfunction

    initial begin
        logic [31:0] sp_pc[3];
        logic [1:0]  sp_c[3];
        logic [UOP_LEN-1:0] exp_u;
        logic [31:0] last_pc;

        sp_pc = '{32'h8000_0000, 32'h8000_0002, 32'h8000_0006};
        sp_c  = '{2'b01, 2'b00, 2'b01};

        vecs[0]  = mk(2'b11, 32'h100, 32'h104, 3'd0, 3'd0, 5'd7, 32'hBEEF, 0, 0, 32'h0,   3'd0, 5'd0, 32'h0,    4'd0);
        vecs[1]  = mk(2'b11, 32'h100, 32'h104, 3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h100, 3'd0, 5'd0, 32'h0,    4'd2);
        vecs[2]  = mk(2'b11, 32'h100, 32'h104, 3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h104, 3'd0, 5'd0, 32'h0,    4'd3);
        vecs[3]  = mk(2'b11, 32'h100, 32'h104, 3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h100, 3'd0, 5'd0, 32'h0,    4'd4);
        vecs[4]  = mk(2'b00, 32'h900, 32'h0,   3'd3, 3'd0, 5'd0, 32'h0,    1, 1, 32'h104, 3'd0, 5'd0, 32'h0,    4'd5);
        vecs[5]  = mk(2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h100, 3'd0, 5'd0, 32'h0,    4'd4);
        vecs[6]  = mk(2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h104, 3'd0, 5'd0, 32'h0,    4'd3);
        vecs[7]  = mk(2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h100, 3'd0, 5'd0, 32'h0,    4'd2);
        vecs[8]  = mk(2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h104, 3'd0, 5'd0, 32'h0,    4'd1);
        vecs[9]  = mk(2'b01, 32'h200, 32'h204, 3'd0, 3'd1, 5'd2, 32'hDEAD, 0, 0, 32'h0,   3'd0, 5'd0, 32'h0,    4'd0);
        vecs[10] = mk(2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'd0, 32'h0,    1, 1, 32'h200, 3'd0, 5'd0, 32'h0,    4'd2);
        vecs[11] = mk(2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'd0, 32'h0,    1, 0, 32'h204, 3'd1, 5'd2, 32'hDEAD, 4'd1);
        vecs[12] = mk(2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'd0, 32'h0,    0, 0, 32'h0,   3'd0, 5'd0, 32'h0,    4'd0);

        rst = 1'b1;
        idle();
        advance();
        advance();
        rst = 1'b0;
        @(negedge clk);
        cmp("reset.uop", 64'(uop_entry), 64'h0);
        cmp("reset.occ", 64'(occupancy), 64'h0);
        cmp("reset.ovf", 64'(overflow), 64'h0);
        cmp("reset.drops", 64'(drop_cnt), 64'h0);
        advance();

        // Dual commit, ignored special slot, trap alignment.
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].v, vecs[i].pc0, vecs[i].pc1, 2'b00, vecs[i].it0,
                           vecs[i].it1, 2'b11, vecs[i].ca, vecs[i].tv);
            @(negedge clk);
            exp_u = vecs[i].e_any ? {vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_it, 1'b0, 2'b11} : '0;
            cmp($sformatf("vec%0d.uop", i), 64'(uop_entry), 64'(exp_u));
            cmp($sformatf("vec%0d.cause", i), 64'(cause_out), 64'(vecs[i].e_ca));
            cmp($sformatf("vec%0d.tval", i), 64'(tval_out), 64'(vecs[i].e_tv));
            cmp($sformatf("vec%0d.occ", i), 64'(occupancy), 64'(vecs[i].e_occ));
            advance();
        end

        // Single-port stream: each PC shows up exactly one cycle later.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) apply_stimulus(2'b01, sp_pc[i], 32'h0, sp_c[i], 3'd0, 3'd0, 2'b01, 5'd0, 32'h0);
            else idle();
            @(negedge clk);
            check_output($sformatf("stream%0d", i));
            if (i > 0) cmp($sformatf("stream%0d.pc", i), 64'(out_pc()), 64'(sp_pc[i-1]));
            cmp($sformatf("stream%0d.occ_le1", i), 64'(occupancy <= 1), 64'h1);
            advance();
        end

        // Overflow: 16 slots offered over 8 cycles into an 8-deep FIFO.
        emitted.delete();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(2'b11, 32'h3000 + 8*i, 32'h3004 + 8*i, 2'b00, 3'd0, 3'd0, 2'b00, 5'd0, 32'h0);
            @(negedge clk);
            check_output($sformatf("ovf_fill%0d", i));
            if (uop_entry[UOP_LEN-1]) emitted.push_back(out_pc());
            advance();
        end
        idle();
        @(negedge clk);
        cmp("ovf.occ_full", 64'(occupancy), 64'd8);
        cmp("ovf.flag", 64'(overflow), 64'h1);
        cmp("ovf.drops", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check_output($sformatf("ovf_drain%0d", i));
            if (uop_entry[UOP_LEN-1]) emitted.push_back(out_pc());
            advance();
        end
        cmp("ovf.emitted_count", 64'(emitted.size()), 64'd15);
        for (int j = 0; j < emitted.size() && j < 15; j++)
            cmp($sformatf("ovf.order%0d", j), 64'(emitted[j]), 64'(32'h3000 + 4*j));

        // Reset mid-stream, alongside a push, with overflow already sticky.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(2'b11, 32'h4000 + 8*i, 32'h4004 + 8*i, 2'b00, 3'd0, 3'd0, 2'b00, 5'd0, 32'h0);
            @(negedge clk);
            check_output($sformatf("rst_fill%0d", i));
            advance();
        end
        apply_stimulus(2'b01, 32'h5000, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 5'd0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        cmp("rst.occ_before", 64'(occupancy), 64'd5);
        advance();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cmp($sformatf("rst%0d.occ", i), 64'(occupancy), 64'h0);
            cmp($sformatf("rst%0d.uop", i), 64'(uop_entry), 64'h0);
            cmp($sformatf("rst%0d.ovf", i), 64'(overflow), 64'h0);
            cmp($sformatf("rst%0d.drops", i), 64'(drop_cnt), 64'h0);
            advance();
        end

        // Wrap-around: 3*DEPTH single entries pass straight through.
        last_pc = 32'h0;
        for (int i = 0; i <= 3*DEPTH; i++) begin
            if (i < 3*DEPTH) apply_stimulus(2'b01, 32'h7000 + 4*i, 32'h0, 2'b00, 3'd0, 3'd0, 2'b10, 5'd0, 32'h0);
            else idle();
            @(negedge clk);
            check_output($sformatf("wrap%0d", i));
            if (i > 0) cmp($sformatf("wrap%0d.pc", i), 64'(out_pc()), 64'(last_pc));
            last_pc = 32'h7000 + 4*i;
            advance();
        end

        // Random traffic, traps and occasional resets against the model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom),
                           ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 4)) : 3'd0,
                           ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 4)) : 3'd0,
                           2'($urandom), 5'($urandom), $urandom);
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            check_output($sformatf("rand%0d", i));
            advance();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
